// File: rtl/memory_arbiter_pkg.sv
// Shared types for the memory arbiter: register-width value type, arbiter
// FSM states and a helper that sizes port-index fields.
package memory_arbiter_pkg;

  localparam int REG_WIDTH = 32;

  typedef logic [REG_WIDTH-1:0] regval_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arbiter_state_t;

  // Width of a field holding a port index; never narrower than one bit so a
  // single-port build still has a legal owner register.
  function automatic int index_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/memory_arbiter_round_robin_picker.sv
// Rotating-priority request picker: scans the request vector starting one
// past the last owner, wrapping, and returns the first requester as a one-hot
// winner together with a valid flag.
module round_robin_picker
  import memory_arbiter_pkg::*;
#(
  parameter int PORT_COUNT = 3,
  localparam int INDEX_W = index_width(PORT_COUNT)
) (
  input  logic [PORT_COUNT-1:0] request,
  input  logic [INDEX_W-1:0]    last_owner,
  output logic [PORT_COUNT-1:0] winner,
  output logic                  valid
);

  int                 candidate;
  logic [INDEX_W-1:0] candidate_index;

  // Walk the ports in priority order and keep only the first one asserted.
  always_comb begin
    winner          = '0;
    valid           = 1'b0;
    candidate       = 0;
    candidate_index = '0;
    for (int offset = 1; offset <= PORT_COUNT; offset++) begin
      candidate = int'(last_owner) + offset;
      if (candidate >= PORT_COUNT) begin
        candidate = candidate - PORT_COUNT;
      end
      candidate_index = INDEX_W'(candidate);
      if (!valid && request[candidate_index]) begin
        winner[candidate_index] = 1'b1;
        valid                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving several requesters access to one memory port,
// with a single transaction outstanding at a time (IDLE -> ISSUE -> WAIT).
// Optional watchdog enabled by defining MEMORY_ARBITER_TIMEOUT_EN: a stuck
// transaction is abandoned after TIMEOUT_CYCLES and reported via error.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int PORT_COUNT     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [PORT_COUNT-1:0]        req_valid,
  input  logic [PORT_COUNT-1:0]        req_write,
  input  regval_t [PORT_COUNT-1:0]     req_address,
  input  regval_t [PORT_COUNT-1:0]     req_data,
  output logic [PORT_COUNT-1:0]        req_grant,
  output logic [PORT_COUNT-1:0]        resp_valid,
  output regval_t                      resp_data,
  output regval_t                      mem_address,
  output regval_t                      mem_write_data,
  output logic                         mem_read_enable,
  output logic                         mem_write_enable,
  input  logic                         mem_ready,
  input  logic                         mem_done,
  input  regval_t                      mem_read_data,
  output logic                         error
);

  localparam int INDEX_W = index_width(PORT_COUNT);

  // Reject parameter values outside the supported range at elaboration.
  if (PORT_COUNT < 1 || PORT_COUNT > 8) begin : g_bad_port_count
    $error("memory_arbiter: PORT_COUNT must be 1..8");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("memory_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arbiter_state_t          state;
  arbiter_state_t          state_next;
  logic [INDEX_W-1:0]      owner;
  logic [INDEX_W-1:0]      pick_index;
  logic [PORT_COUNT-1:0]   pick_winner;
  logic                    pick_valid;
  regval_t                 cmd_address;
  regval_t                 cmd_data;
  logic                    cmd_write;
  logic                    first_issue;
  logic [PORT_COUNT-1:0]   resp_valid_q;
  regval_t                 resp_data_q;
  logic                    error_q;
  logic                    done_hit;
  logic                    timeout_hit;
  logic                    timeout_fire;

  // The owner register doubles as "last owner" for the rotating priority.
  round_robin_picker #(
    .PORT_COUNT (PORT_COUNT)
  ) picker (
    .request    (req_valid),
    .last_owner (owner),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  // Convert the one-hot winner into an index for capture and ownership.
  always_comb begin
    pick_index = '0;
    for (int i = 0; i < PORT_COUNT; i++) begin
      if (pick_winner[i]) begin
        pick_index = INDEX_W'(i);
      end
    end
  end

  assign done_hit = (state == WAIT) && mem_done;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
  logic [15:0] timeout_count;

  assign timeout_hit = ((state == ISSUE) || (state == WAIT)) &&
                       (timeout_count == 16'(TIMEOUT_CYCLES - 1));

  // Count cycles spent on the current transaction, restarting at each capture.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout_count <= '0;
    end else if (state == IDLE) begin
      timeout_count <= '0;
    end else begin
      timeout_count <= timeout_count + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // A real completion arriving in the same cycle as the watchdog wins.
  assign timeout_fire = timeout_hit && !done_hit;

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state selection and the combinational command/grant outputs.
  always_comb begin
    state_next       = state;
    req_grant        = '0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        mem_read_enable  = !cmd_write;
        mem_write_enable = cmd_write;
        if (first_issue) begin
          req_grant[owner] = 1'b1;
        end
        if (timeout_fire) begin
          state_next = IDLE;
        end else if (mem_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (done_hit || timeout_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the winning command, track ownership and register responses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner        <= INDEX_W'(PORT_COUNT - 1);
      cmd_address  <= '0;
      cmd_data     <= '0;
      cmd_write    <= 1'b0;
      first_issue  <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      error_q      <= 1'b0;
    end else begin
      resp_valid_q <= '0;
      error_q      <= 1'b0;
      if (state == IDLE && pick_valid) begin
        owner       <= pick_index;
        cmd_address <= req_address[pick_index];
        cmd_data    <= req_data[pick_index];
        cmd_write   <= req_write[pick_index];
        first_issue <= 1'b1;
      end
      if (state == ISSUE) begin
        first_issue <= 1'b0;
      end
      if (done_hit) begin
        resp_valid_q[owner] <= 1'b1;
        resp_data_q         <= cmd_write ? '0 : mem_read_data;
      end
      if (timeout_fire) begin
        resp_valid_q[owner] <= 1'b1;
        resp_data_q         <= '0;
        error_q             <= 1'b1;
      end
    end
  end

  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign error          = error_q;
  assign mem_address    = cmd_address;
  assign mem_write_data = cmd_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: table of single transactions plus
// hand-written fairness, backpressure, reset and watchdog sequences. Grants and
// responses are checked against scoreboard queues filled as stimulus is driven.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int PORTS   = 3;
  localparam int TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [PORTS-1:0]  req_valid = '0;
  logic [PORTS-1:0]  req_write = '0;
  regval_t [PORTS-1:0] req_address = '0;
  regval_t [PORTS-1:0] req_data = '0;
  logic [PORTS-1:0]  req_grant;
  logic [PORTS-1:0]  resp_valid;
  regval_t           resp_data;
  regval_t           mem_address;
  regval_t           mem_write_data;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic              mem_ready = 1'b0;
  logic              mem_done = 1'b0;
  regval_t           mem_read_data = '0;
  logic              error;

  typedef struct {
    int      port;
    logic    write;
    regval_t address;
    regval_t wdata;
    regval_t rdata;
    int      stall;
    regval_t expect_data;
  } vector_t;

  typedef struct {
    int      port;
    regval_t data;
    logic    error;
  } resp_exp_t;

  int        grant_q[$];
  resp_exp_t resp_q[$];
  vector_t   vectors[5];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int grant_cycle = 0;
  int resp_cycle = 0;
  int grant_count = 0;
  int resp_count = 0;
  int issue_cycles = 0;
  int cur_owner = 0;
  int stall_left = 0;
  logic done_enable = 1'b1;
  logic spurious_done = 1'b0;
  logic accept_pending = 1'b0;
  regval_t exp_addr[PORTS];
  regval_t exp_wdata[PORTS];
  regval_t exp_rdata[PORTS];
  logic    exp_write[PORTS];

  memory_arbiter #(
    .PORT_COUNT     (PORTS),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_address      (req_address),
    .req_data         (req_data),
    .req_grant        (req_grant),
    .resp_valid       (resp_valid),
    .resp_data        (resp_data),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_ready        (mem_ready),
    .mem_done         (mem_done),
    .mem_read_data    (mem_read_data),
    .error            (error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=still_running expected=finished");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string detail);
    checks++;
    errors++;
    $display("[TB] FAIL %s %s", name, detail);
  endtask

  // Monitor (grant/command/response scoreboard) and memory responder.
  always @(negedge clock) begin
    int        p;
    resp_exp_t e;
    if (!reset_n) begin
      mem_ready      = 1'b0;
      mem_done       = 1'b0;
      accept_pending = 1'b0;
    end else begin
      if (req_grant != '0) begin
        if (grant_q.size() == 0) begin
          reportFail("unexpected_grant", $sformatf("actual=%b expected=none", req_grant));
        end else begin
          p = grant_q.pop_front();
          checkOutput("grant_port", 32'(req_grant), 32'(1) << p);
          cur_owner = p;
        end
        grant_cycle = cycle;
        grant_count++;
      end
      if (mem_read_enable || mem_write_enable) begin
        issue_cycles++;
        checkOutput("write_enable", 32'(mem_write_enable), 32'(exp_write[cur_owner]));
        checkOutput("read_enable", 32'(mem_read_enable), 32'(!exp_write[cur_owner]));
        checkOutput("mem_address", mem_address, exp_addr[cur_owner]);
        if (exp_write[cur_owner]) begin
          checkOutput("mem_write_data", mem_write_data, exp_wdata[cur_owner]);
        end
      end
      if (resp_valid != '0) begin
        if (resp_q.size() == 0) begin
          reportFail("unexpected_resp", $sformatf("actual=%b expected=none", resp_valid));
        end else begin
          e = resp_q.pop_front();
          checkOutput("resp_port", 32'(resp_valid), 32'(1) << e.port);
          checkOutput("resp_data", resp_data, e.data);
          checkOutput("resp_error", 32'(error), 32'(e.error));
        end
        resp_cycle = cycle;
        resp_count++;
      end else if (error) begin
        reportFail("error_without_resp", "actual=1 expected=0");
      end
      mem_done = spurious_done;
      if (accept_pending) begin
        accept_pending = 1'b0;
        mem_done       = done_enable | spurious_done;
        mem_read_data  = exp_rdata[cur_owner];
      end
      if (mem_read_enable || mem_write_enable) begin
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
        end else begin
          mem_ready      = 1'b1;
          accept_pending = 1'b1;
        end
      end else begin
        mem_ready = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic waitGrants(input int target, input int budget, input string name);
    int n = 0;
    while (grant_count < target && n < budget) begin
      tick();
      n++;
    end
    if (grant_count < target) reportFail(name, "actual=no_grant expected=grant");
  endtask

  task automatic waitResps(input int target, input int budget, input string name);
    int n = 0;
    while (resp_count < target && n < budget) begin
      tick();
      n++;
    end
    if (resp_count < target) reportFail(name, "actual=no_resp expected=resp");
  endtask

  task automatic loadPort(input vector_t v);
    exp_addr[v.port]    = v.address;
    exp_wdata[v.port]   = v.wdata;
    exp_rdata[v.port]   = v.rdata;
    exp_write[v.port]   = v.write;
    req_write[v.port]   = v.write;
    req_address[v.port] = v.address;
    req_data[v.port]    = v.wdata;
  endtask

  task automatic pushResp(input int port, input regval_t data, input logic err);
    resp_exp_t e;
    e.port  = port;
    e.data  = data;
    e.error = err;
    resp_q.push_back(e);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    req_valid = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Drive one complete transaction on a single port and check its latency.
  task automatic applyStimulus(input vector_t v, input string name);
    int g0, r0, drive_cycle;
    loadPort(v);
    stall_left = v.stall;
    grant_q.push_back(v.port);
    pushResp(v.port, v.expect_data, 1'b0);
    g0 = grant_count;
    r0 = resp_count;
    drive_cycle = cycle;
    req_valid[v.port] = 1'b1;
    waitGrants(g0 + 1, 20, {name, "_grant_wait"});
    req_valid[v.port] = 1'b0;
    waitResps(r0 + 1, 30, {name, "_resp_wait"});
    if (v.stall == 0) begin
      checkOutput({name, "_grant_latency"}, grant_cycle - drive_cycle, 1);
      checkOutput({name, "_resp_latency"}, resp_cycle - drive_cycle, 3);
    end
  endtask

  initial begin
    int g0, r0, i0;
    vector_t v;

    vectors[0] = '{1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF};
    vectors[1] = '{2, 1'b1, 32'h0000_0200, 32'h1234_5678, 32'hAAAA_5555, 0, 32'h0};
    vectors[2] = '{0, 1'b0, 32'h0000_03FC, 32'h0, 32'hCAFE_F00D, 2, 32'hCAFE_F00D};
    vectors[3] = '{2, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF};
    vectors[4] = '{0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h5555_AAAA, 1, 32'h0};

    // Reset values.
    repeat (3) tick();
    checkOutput("rst_grant", 32'(req_grant), 0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 0);
    checkOutput("rst_enables", {30'd0, mem_read_enable, mem_write_enable}, 0);
    checkOutput("rst_mem_address", mem_address, 0);
    checkOutput("rst_error", 32'(error), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
    end

    // Fairness: all ports request continuously after a fresh reset.
    doReset();
    for (int p = 0; p < PORTS; p++) begin
      v = '{p, 1'b0, 32'h1000 + 32'(p * 4), 32'h0, 32'hF00D_0000 + 32'(p), 0, 32'h0};
      loadPort(v);
    end
    for (int n = 0; n < 6; n++) begin
      grant_q.push_back(n % PORTS);
      pushResp(n % PORTS, 32'hF00D_0000 + 32'(n % PORTS), 1'b0);
    end
    g0 = grant_count;
    r0 = resp_count;
    req_valid = '1;
    waitGrants(g0 + 6, 60, "fair_grant_wait");
    req_valid = '0;
    waitResps(r0 + 6, 60, "fair_resp_wait");
    checkOutput("fair_grant_total", grant_count - g0, 6);

    // Backpressure, with owner inputs scrambled and a withdrawn request.
    v = '{2, 1'b0, 32'h0000_0ABC, 32'h0, 32'h0BAD_F00D, 4, 32'h0BAD_F00D};
    loadPort(v);
    stall_left = 4;
    grant_q.push_back(2);
    pushResp(2, 32'h0BAD_F00D, 1'b0);
    g0 = grant_count;
    r0 = resp_count;
    i0 = issue_cycles;
    req_valid[2] = 1'b1;
    waitGrants(g0 + 1, 20, "bp_grant_wait");
    req_valid[2] = 1'b0;
    req_address[2] = 32'hBAD0_BAD0;
    req_write[2] = 1'b1;
    req_valid[1] = 1'b1;
    tick();
    tick();
    req_valid[1] = 1'b0;
    waitResps(r0 + 1, 30, "bp_resp_wait");
    repeat (3) tick();
    checkOutput("bp_issue_cycles", issue_cycles - i0, 5);
    checkOutput("bp_grant_total", grant_count - g0, 1);
    checkOutput("bp_resp_total", resp_count - r0, 1);

    // Stray mem_done while idle must not produce a response.
    spurious_done = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      checkOutput("stray_done_resp", 32'(resp_valid), 0);
    end
    spurious_done = 1'b0;

    // Reset while waiting on memory, then port 0 must win over port 2.
    done_enable = 1'b0;
    v = '{1, 1'b0, 32'h0000_0444, 32'h0, 32'h7777_7777, 0, 32'h0};
    loadPort(v);
    grant_q.push_back(1);
    g0 = grant_count;
    req_valid[1] = 1'b1;
    waitGrants(g0 + 1, 20, "rstw_grant_wait");
    req_valid[1] = 1'b0;
    tick();
    tick();
    checkOutput("rstw_in_wait", {30'd0, mem_read_enable, mem_write_enable}, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("rstw_resp_valid", 32'(resp_valid), 0);
    checkOutput("rstw_resp_data", resp_data, 0);
    checkOutput("rstw_mem_address", mem_address, 0);
    checkOutput("rstw_error", 32'(error), 0);
    done_enable = 1'b1;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    loadPort('{0, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_1010, 0, 32'h0});
    loadPort('{2, 1'b1, 32'h0000_0020, 32'h2020_2020, 32'h0, 0, 32'h0});
    grant_q.push_back(0);
    grant_q.push_back(2);
    pushResp(0, 32'h0000_1010, 1'b0);
    pushResp(2, 32'h0, 1'b0);
    g0 = grant_count;
    r0 = resp_count;
    req_valid = 3'b101;
    waitGrants(g0 + 1, 20, "rstw_first_wait");
    req_valid[0] = 1'b0;
    waitGrants(g0 + 2, 20, "rstw_second_wait");
    req_valid[2] = 1'b0;
    waitResps(r0 + 2, 30, "rstw_resp_wait");

    // Memory that never completes.
    doReset();
    done_enable = 1'b0;
    v = '{0, 1'b0, 32'h0000_0040, 32'h0, 32'h1111_1111, 0, 32'h0};
    loadPort(v);
    grant_q.push_back(0);
    g0 = grant_count;
    r0 = resp_count;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    pushResp(0, 32'h0, 1'b1);
    req_valid[0] = 1'b1;
    waitGrants(g0 + 1, 20, "to_grant_wait");
    req_valid[0] = 1'b0;
    waitResps(r0 + 1, 40, "to_resp_wait");
    checkOutput("to_latency", resp_cycle - grant_cycle, TIMEOUT);
    done_enable = 1'b1;
    applyStimulus('{1, 1'b0, 32'h0000_0050, 32'h0, 32'h2222_2222, 0, 32'h2222_2222}, "to_after");
`else
    req_valid[0] = 1'b1;
    waitGrants(g0 + 1, 20, "hang_grant_wait");
    req_valid[0] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      repeat (10) tick();
      checkOutput("hang_error", 32'(error), 0);
      checkOutput("hang_resp_total", resp_count - r0, 0);
    end
    req_valid[2] = 1'b1;
    repeat (10) tick();
    checkOutput("hang_no_new_grant", grant_count - g0, 1);
    req_valid[2] = 1'b0;
    done_enable = 1'b1;
    doReset();
`endif

    checkOutput("grant_queue_empty", grant_q.size(), 0);
    checkOutput("resp_queue_empty", resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 3, number of requester ports (instruction, data-read, data-write), legal 1..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles, legal 1..65535; used only under REQ-024.
REQ-003 SHALL have ports: clock  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  PORT_COUNT  request pending per port, held until granted.
REQ-006 req_write  input  PORT_COUNT  1 = write, 0 = read.
REQ-007 req_address, req_data  input  PORT_COUNT x regval_t  address and write data per port.
REQ-008 req_grant  output  PORT_COUNT  one-hot, one-cycle pulse: request accepted.
REQ-009 resp_valid  output  PORT_COUNT  one-hot, one-cycle pulse: transaction complete.
REQ-010 resp_data  output  regval_t  read data, shared, valid with resp_valid.
REQ-011 mem_address, mem_write_data  output  regval_t; mem_read_enable, mem_write_enable  output  1.
REQ-012 mem_ready  input  1  command accepted; mem_done  input  1  completion; mem_read_data  input  regval_t.
REQ-013 error  output  1  timeout pulse.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT; one transaction outstanding.
REQ-015 IDLE: if any req_valid, SHALL register the winner's command, record owner, enter ISSUE next cycle; else stay.
REQ-016 Winner SHALL be first asserted port scanning from (last_owner+1) mod PORT_COUNT upward, wrapping.
REQ-017 ISSUE: SHALL drive registered address/data and exactly one of mem_read_enable/mem_write_enable; req_grant[owner] high only in the first ISSUE cycle.
REQ-018 ISSUE with mem_ready=1: SHALL enter WAIT next cycle with enables low; mem_ready=0: hold command unchanged.
REQ-019 WAIT with mem_done=1: SHALL register mem_read_data (0 for writes) into resp_data, pulse resp_valid[owner] next cycle, return to IDLE that same cycle.
REQ-020 mem_done outside WAIT and mem_ready outside ISSUE SHALL be ignored.
REQ-021 Minimum latency: req_valid sampled at edge k, grant and enables at k+1, resp_valid at k+3 with zero-wait memory; next arbitration in the resp_valid cycle.
REQ-022 Port deasserting req_valid before grant SHALL be withdrawn; req_* of the owner SHALL be ignored after capture.

Reset
REQ-023 reset_n low SHALL asynchronously force IDLE, all outputs 0, last_owner = PORT_COUNT-1 (port 0 wins first); in-flight transaction discarded, no resp_valid.

Configuration
REQ-024 With MEMORY_ARBITER_TIMEOUT_EN defined: counter SHALL clear on entering ISSUE, count in ISSUE/WAIT; on reaching TIMEOUT_CYCLES SHALL return to IDLE and pulse resp_valid[owner] and error together next cycle, resp_data = 0.
REQ-025 Without MEMORY_ARBITER_TIMEOUT_EN: no counter; error tied 0; arbiter waits indefinitely.

Structure
REQ-026 regval_t and enum arbiter_state_t (IDLE, ISSUE, WAIT) SHALL live in the shared package.
REQ-027 Rotating priority search SHALL be sub-module round_robin_picker (request vector, last owner -> one-hot winner, valid).

Verification
REQ-028 Single read: port 1 reads 0x100, mem_ready/mem_done immediate, mem_read_data 0xDEADBEEF -> grant[1] at k+1, resp_valid[1] with 0xDEADBEEF at k+3.
REQ-029 Fairness: all three ports request continuously, PORT_COUNT=3 -> grants in order 0,1,2,0,1,2.
REQ-030 Backpressure: mem_ready low 4 cycles -> command stable 5 ISSUE cycles, one grant pulse, one resp_valid.
REQ-031 Reset during WAIT -> outputs 0 immediately, no resp_valid, next request from port 0 granted first.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=8): mem_done never asserted -> error and resp_valid[owner] pulse together, resp_data 0, IDLE after; macro off -> stays in WAIT, error 0.
